pspin_stdout_fifo: RTL and testbench
====================================

# pspin_stdout_fifo

Buffers stdout words written by PsPIN cluster cores (printf output decoded from the stdout MMIO region) and presents them to the host control-register block as a first-word-fall-through stream. Sits between the PsPIN-side stdout write decoder (push side) and the AXI-Lite control-register block, which pops one word per host read of the stdout FIFO register. Never back-pressures cores in drop mode. Counts words discarded while full so the host can detect lost output.

## Interface
Parameters:
- DEPTH, 1024: RAM entries; power of two, ≥ 4.
- DROP_WHEN_FULL, 1: 1 = in_ready tied high, overflow words dropped and counted; 0 = in_ready deasserts when full.
- CNT_WIDTH, 16: drop counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high; clock clk.
- in_valid  in  1  push word valid.
- in_ready  out  1  push accept.
- in_data  in  32  stdout word: [31:24] cluster/core id, [23:0] payload, opaque here.
- stdout_rd_en  in  1  pop strobe; one cycle per consumed word.
- stdout_dout  out  32  head word.
- stdout_data_valid  out  1  stdout_dout holds a valid word.
- fill_level  out  $clog2(DEPTH)+1  words held: RAM + output stage.
- drop_count  out  CNT_WIDTH  saturating count of discarded pushes.
- drop_clear  in  1  synchronous clear of drop_count.

## Operation
- Push handshake: in_valid && in_ready. Accepted word is written at RAM[wr_ptr]; wr_ptr increments modulo DEPTH.
- in_ready (DROP_WHEN_FULL=0) = fill_level < DEPTH. It is a registered decode with no combinational path from stdout_rd_en.
- Drop: with DROP_WHEN_FULL=1, in_valid while fill_level == DEPTH discards the word, leaves the FIFO unchanged, and increments drop_count. drop_count saturates at all-ones.
- drop_clear has priority; a simultaneous drop yields drop_count = 1.
- Output stage: 2-entry register skid (head, next) fed from RAM synchronous reads.
  - A RAM read is issued whenever RAM is non-empty and the skid will have a free slot next cycle.
  - stdout_dout/stdout_data_valid come from head.
- Pop: stdout_rd_en && stdout_data_valid removes head; next moves to head. stdout_rd_en while !stdout_data_valid is ignored.
- fill_level arithmetic:
  - +1 per accepted push, −1 per effective pop; unchanged on simultaneous push and pop.
  - Never exceeds DEPTH, never underflows.
  - Words in flight between RAM and skid are counted.
- Pointer wrap: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from fill_level, not pointer compare.
- Reset (including mid-operation): discards all contents; pointers, fill_level, drop_count, skid valids cleared.

## Timing
- Reset values: in_ready 0 while rst high, then 1 from the first cycle after deassert. stdout_dout 0, stdout_data_valid 0, fill_level 0, drop_count 0.
- Push-to-visible latency into an empty FIFO: word accepted in cycle T gives stdout_data_valid = 1 with that word in cycle T+2.
- Back-to-back pop: if the skid holds two words in cycle P and stdout_rd_en = 1, the next word is on stdout_dout in P+1 with valid held high. Sustained throughput is 1 word/cycle.
- Pop with only one word buffered: stdout_data_valid = 0 in P+1.
- fill_level and in_ready update one cycle after the causing handshake.
- Full with simultaneous pop and push:
  - DROP_WHEN_FULL=0: in_ready is already 0, so the push is not taken.
  - DROP_WHEN_FULL=1: the push is dropped, because the full decision uses the registered fill_level.

## Structure
- Shared include pspin_defs.vh holds:
  - STDOUT_WORD_WIDTH = 32.
  - Stdout word field offsets (id [31:24], payload [23:0]).
  - Stdout MMIO offset 0x1000, shared with the control-register block.
- One sub-module, pspin_sdp_ram: simple dual-port, 1 write / 1 read port, 1-cycle registered read, no reset on storage. All FIFO control stays in pspin_stdout_fifo.

## Test plan
- Reset then single push of 0xA5000041 → stdout_data_valid = 1 with dout 0xA5000041 two cycles later; fill_level = 1. One stdout_rd_en → valid 0, fill_level 0.
- Stream 0..99, pop every cycle once valid → words popped in order 0..99, valid continuously high after the first word, drop_count 0.
- DROP_WHEN_FULL=1, DEPTH=16: push 20 words with no pops → fill_level 16, drop_count 4; popped words are 0..15.
- DROP_WHEN_FULL=0, DEPTH=16 full:
  - With in_valid held high, in_ready = 0.
  - One pop gives in_ready = 1 next cycle; a push is then accepted.
  - fill_level returns to 16, ordering preserved across pointer wrap.
- stdout_rd_en pulsed while empty → no state change, fill_level stays 0. drop_clear asserted in the same cycle as a drop → drop_count = 1.
- Assert rst mid-stream with 10 words buffered → all outputs at reset values. Fresh push 0x12345678 after deassert → it is the first word read.

Source files
------------

// File: rtl/pspin_stdout_fifo_pkg.sv
// Shared stdout definitions for the PsPIN stdout path: word layout and MMIO placement.
package pspin_stdout_fifo_pkg;

  localparam int unsigned STDOUT_WORD_WIDTH  = 32;
  localparam int unsigned STDOUT_ID_MSB      = 31;
  localparam int unsigned STDOUT_ID_LSB      = 24;
  localparam int unsigned STDOUT_PAYLOAD_MSB = 23;
  localparam int unsigned STDOUT_PAYLOAD_LSB = 0;
  localparam logic [31:0] STDOUT_MMIO_OFFSET = 32'h0000_1000;

  typedef logic [STDOUT_WORD_WIDTH-1:0] stdout_word_t;

  function automatic logic [7:0] stdout_word_id(stdout_word_t w);
    return w[STDOUT_ID_MSB:STDOUT_ID_LSB];
  endfunction

  function automatic logic [23:0] stdout_word_payload(stdout_word_t w);
    return w[STDOUT_PAYLOAD_MSB:STDOUT_PAYLOAD_LSB];
  endfunction

endpackage

// File: rtl/pspin_stdout_fifo_if.sv
// Push (core side) and pop (control-register side) signals of the stdout FIFO.
interface pspin_stdout_fifo_if;
  import pspin_stdout_fifo_pkg::*;

  logic         in_valid;
  logic         in_ready;
  stdout_word_t in_data;
  logic         stdout_rd_en;
  stdout_word_t stdout_dout;
  logic         stdout_data_valid;

  modport master (
    output in_valid, in_data, stdout_rd_en,
    input  in_ready, stdout_dout, stdout_data_valid
  );

  modport slave (
    input  in_valid, in_data, stdout_rd_en,
    output in_ready, stdout_dout, stdout_data_valid
  );

endinterface

// File: rtl/pspin_stdout_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a 1-cycle registered read.
module pspin_sdp_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write-first on an address collision so a word can be read in the cycle it is written.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
  end

endmodule

// File: rtl/pspin_stdout_fifo.sv
// Stdout word FIFO: RAM backing store plus a 2-entry FWFT output skid, with drop counting.
module pspin_stdout_fifo
  import pspin_stdout_fifo_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter bit          DROP_WHEN_FULL = 1'b1,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pspin_stdout_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [CNT_WIDTH-1:0]   drop_count,
  input  logic                   drop_clear
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam int unsigned     LW       = AW + 1;
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        fill_q, fill_d, ram_cnt_q, ram_cnt_d;
  logic                 rdy_q, rdy_d, fl_q, fl_d;
  logic                 head_v_q, head_v_d, next_v_q, next_v_d;
  stdout_word_t         head_q, head_d, next_q, next_d, ram_rdata;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 full, push, pop, drop, rd_issue;
  logic [1:0]           occ_after;

  pspin_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (STDOUT_WORD_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    full      = (fill_q == FULL_LVL);
    push      = bus.in_valid && rdy_q && !full;
    drop      = DROP_WHEN_FULL && bus.in_valid && full;
    pop       = bus.stdout_rd_en && head_v_q;
    // Skid + in-flight read occupancy after this edge; a new read must still fit next edge.
    occ_after = 2'(head_v_q) + 2'(next_v_q) + 2'(fl_q) - 2'(pop);
    rd_issue  = ((ram_cnt_q != '0) || push) && (occ_after <= 2'd1);

    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ram_cnt_d = ram_cnt_q + LW'(push) - LW'(rd_issue);
    fill_d    = fill_q + LW'(push) - LW'(pop);
    rdy_d     = DROP_WHEN_FULL ? 1'b1 : (fill_d < FULL_LVL);
    fl_d      = rd_issue;

    head_d   = head_q;
    head_v_d = head_v_q;
    next_d   = next_q;
    next_v_d = next_v_q;
    if (pop) begin
      head_d   = next_q;
      head_v_d = next_v_q;
      next_v_d = 1'b0;
    end
    if (fl_q) begin
      if (!head_v_d) begin
        head_d   = ram_rdata;
        head_v_d = 1'b1;
      end else begin
        next_d   = ram_rdata;
        next_v_d = 1'b1;
      end
    end

    drop_d = drop_q;
    if (drop_clear)                drop_d = drop ? CNT_WIDTH'(1) : '0;
    else if (drop && drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      ram_cnt_q <= '0;
      rdy_q     <= 1'b0;
      fl_q      <= 1'b0;
      head_v_q  <= 1'b0;
      next_v_q  <= 1'b0;
      head_q    <= '0;
      next_q    <= '0;
      drop_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      ram_cnt_q <= ram_cnt_d;
      rdy_q     <= rdy_d;
      fl_q      <= fl_d;
      head_v_q  <= head_v_d;
      next_v_q  <= next_v_d;
      head_q    <= head_d;
      next_q    <= next_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.in_ready          = rdy_q;
  assign bus.stdout_dout       = head_q;
  assign bus.stdout_data_valid = head_v_q;
  assign fill_level            = fill_q;
  assign drop_count            = drop_q;

endmodule

// File: tb/tb_pspin_stdout_fifo.sv
// Bench for pspin_stdout_fifo: a drop-mode and a back-pressure instance against a queue-level model.
module tb_pspin_stdout_fifo;
  import pspin_stdout_fifo_pkg::*;

  localparam int unsigned D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pspin_stdout_fifo_if ifa ();
  pspin_stdout_fifo_if ifb ();

  logic        dv  [2];
  logic [31:0] dd  [2];
  logic        drd [2];
  logic        clr [2];
  logic [4:0]  fill_a, fill_b;
  logic [3:0]  dc_a;
  logic [15:0] dc_b;

  assign ifa.in_valid     = dv[0];
  assign ifa.in_data      = dd[0];
  assign ifa.stdout_rd_en = drd[0];
  assign ifb.in_valid     = dv[1];
  assign ifb.in_data      = dd[1];
  assign ifb.stdout_rd_en = drd[1];

  pspin_stdout_fifo #(.DEPTH(D), .DROP_WHEN_FULL(1'b1), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .bus(ifa), .fill_level(fill_a), .drop_count(dc_a), .drop_clear(clr[0]));
  pspin_stdout_fifo #(.DEPTH(D), .DROP_WHEN_FULL(1'b0), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .bus(ifb), .fill_level(fill_b), .drop_count(dc_b), .drop_clear(clr[1]));

  logic        ov [2];
  logic        ordy [2];
  logic [31:0] od [2];
  int unsigned ofl [2];
  int unsigned odc [2];
  always_comb begin
    ov[0] = ifa.stdout_data_valid;  ov[1] = ifb.stdout_data_valid;
    ordy[0] = ifa.in_ready;         ordy[1] = ifb.in_ready;
    od[0] = ifa.stdout_dout;        od[1] = ifb.stdout_dout;
    ofl[0] = 32'(fill_a);           ofl[1] = 32'(fill_b);
    odc[0] = 32'(dc_a);             odc[1] = 32'(dc_b);
  end

  // Reference model: each FIFO is a list of (word, accept cycle); the oldest word is
  // visible once two cycles have passed since its acceptance.
  logic [31:0] mw [2][D];
  int unsigned mt [2][D];
  int unsigned mh [2], mn [2], mdc [2];
  bit          men [2];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0, n_fail = 0;

  function automatic int unsigned dc_max(int x);
    return (x == 0) ? 15 : 65535;
  endfunction
  function automatic bit exp_valid(int x);
    return (mn[x] > 0) && (mt[x][mh[x]] + 2 <= cyc);
  endfunction
  function automatic logic [31:0] exp_dout(int x);
    return mw[x][mh[x]];
  endfunction
  function automatic bit exp_rdy(int x);
    return men[x] && ((x == 0) || (mn[x] < D));
  endfunction

  task automatic model_clear();
    for (int x = 0; x < 2; x++) begin
      mn[x] = 0; mh[x] = 0; mdc[x] = 0; men[x] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else begin
      for (int x = 0; x < 2; x++) begin
        bit full, push, pop, drop;
        int unsigned idx;
        full = (mn[x] == D);
        pop  = drd[x] && exp_valid(x);
        push = dv[x] && exp_rdy(x) && !full;
        drop = (x == 0) && dv[x] && full;
        if (pop) begin mh[x] = (mh[x] + 1) % D; mn[x]--; end
        if (push) begin
          idx = (mh[x] + mn[x]) % D;
          mw[x][idx] = dd[x]; mt[x][idx] = cyc; mn[x]++;
        end
        if (clr[x]) mdc[x] = drop ? 1 : 0;
        else if (drop && mdc[x] < dc_max(x)) mdc[x]++;
        men[x] = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    for (int x = 0; x < 2; x++) begin
      dv[x] = 1'b0; dd[x] = '0; drd[x] = 1'b0; clr[x] = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    for (int x = 0; x < 2; x++) begin
      n_cmp++; if (ov[x] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %0b want 0", x, ov[x]); end
      n_cmp++; if (od[x] !== 32'h0) begin n_fail++; $display("FAIL reset_dout[%0d]: got %h want 0", x, od[x]); end
      n_cmp++; if (ofl[x] != 0) begin n_fail++; $display("FAIL reset_fill[%0d]: got %0d want 0", x, ofl[x]); end
      n_cmp++; if (odc[x] != 0) begin n_fail++; $display("FAIL reset_drop[%0d]: got %0d want 0", x, odc[x]); end
      n_cmp++; if (ordy[x] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %0b want 0", x, ordy[x]); end
    end
    rst = 1'b0;
    tick();
    for (int x = 0; x < 2; x++) begin
      n_cmp++; if (ordy[x] !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset[%0d]: got %0b want 1", x, ordy[x]); end
    end
  endtask

  task automatic test_single_push();
    dv[0] = 1'b1; dd[0] = 32'hA500_0041;
    tick();
    dv[0] = 1'b0;
    n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b want 0", ov[0]); end
    n_cmp++; if (ofl[0] != 1) begin n_fail++; $display("FAIL single_fill_t1: got %0d want 1", ofl[0]); end
    tick();
    n_cmp++; if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", ov[0]); end
    n_cmp++; if (od[0] !== 32'hA500_0041) begin n_fail++; $display("FAIL single_dout: got %h want a5000041", od[0]); end
    drd[0] = 1'b1;
    tick();
    drd[0] = 1'b0;
    n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %0b want 0", ov[0]); end
    n_cmp++; if (ofl[0] != 0) begin n_fail++; $display("FAIL single_pop_fill: got %0d want 0", ofl[0]); end
  endtask

  task automatic test_stream();
    int unsigned sent = 0, got = 0, gaps = 0;
    bit started = 0;
    drd[0] = 1'b1;
    for (int c = 0; c < 300 && got < 100; c++) begin
      dv[0] = (sent < 100); dd[0] = 32'(sent);
      if (ov[0]) begin
        started = 1;
        n_cmp++; if (od[0] !== 32'(got)) begin n_fail++; $display("FAIL stream_word: got %0d want %0d", od[0], got); end
        got++;
      end else if (started) gaps++;
      tick();
      if (dv[0]) sent++;
    end
    idle();
    n_cmp++; if (got != 100) begin n_fail++; $display("FAIL stream_count: got %0d want 100", got); end
    n_cmp++; if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
    n_cmp++; if (odc[0] != 0) begin n_fail++; $display("FAIL stream_drop: got %0d want 0", odc[0]); end
  endtask

  task automatic test_drop_full();
    int unsigned k = 0;
    for (int i = 0; i < 20; i++) begin
      dv[0] = 1'b1; dd[0] = 32'(i);
      tick();
    end
    idle();
    n_cmp++; if (ofl[0] != 16) begin n_fail++; $display("FAIL dropfull_fill: got %0d want 16", ofl[0]); end
    n_cmp++; if (odc[0] != 4) begin n_fail++; $display("FAIL dropfull_count: got %0d want 4", odc[0]); end
    drd[0] = 1'b1;
    for (int c = 0; c < 40 && k < 16; c++) begin
      if (ov[0]) begin
        n_cmp++; if (od[0] !== 32'(k)) begin n_fail++; $display("FAIL dropfull_word: got %0d want %0d", od[0], k); end
        k++;
      end
      tick();
    end
    idle();
    n_cmp++; if (k != 16) begin n_fail++; $display("FAIL dropfull_drained: got %0d want 16", k); end
    n_cmp++; if (ofl[0] != 0) begin n_fail++; $display("FAIL dropfull_empty: got %0d want 0", ofl[0]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q [$];
    int unsigned k = 0;
    for (int i = 0; i < 20; i++) begin
      dv[1] = 1'b1; dd[1] = 32'hB000_0000 + 32'(i);
      if (i > 0 && i < 16) exp_q.push_back(dd[1]);
      tick();
    end
    n_cmp++; if (ordy[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %0b want 0", ordy[1]); end
    n_cmp++; if (ofl[1] != 16) begin n_fail++; $display("FAIL bp_fill_full: got %0d want 16", ofl[1]); end
    dd[1] = 32'hB000_0100;
    exp_q.push_back(dd[1]);
    drd[1] = 1'b1;
    tick();
    drd[1] = 1'b0;
    n_cmp++; if (ordy[1] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %0b want 1", ordy[1]); end
    n_cmp++; if (ofl[1] != 15) begin n_fail++; $display("FAIL bp_fill_after_pop: got %0d want 15", ofl[1]); end
    tick();
    dv[1] = 1'b0;
    n_cmp++; if (ofl[1] != 16) begin n_fail++; $display("FAIL bp_refill: got %0d want 16", ofl[1]); end
    n_cmp++; if (ordy[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_refull: got %0b want 0", ordy[1]); end
    drd[1] = 1'b1;
    for (int c = 0; c < 40 && k < 16; c++) begin
      if (ov[1]) begin
        n_cmp++; if (od[1] !== exp_q[k]) begin n_fail++; $display("FAIL bp_word: got %h want %h", od[1], exp_q[k]); end
        k++;
      end
      tick();
    end
    idle();
    n_cmp++; if (k != 16) begin n_fail++; $display("FAIL bp_drained: got %0d want 16", k); end
  endtask

  task automatic test_empty_pop_and_clear();
    drd[0] = 1'b1; tick(); drd[0] = 1'b0; tick();
    n_cmp++; if (ofl[0] != 0) begin n_fail++; $display("FAIL emptypop_fill: got %0d want 0", ofl[0]); end
    n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL emptypop_valid: got %0b want 0", ov[0]); end
    for (int i = 0; i < 16; i++) begin
      dv[0] = 1'b1; dd[0] = $urandom; tick();
    end
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    n_cmp++; if (odc[0] != 1) begin n_fail++; $display("FAIL clear_with_drop: got %0d want 1", odc[0]); end
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (odc[0] != 15) begin n_fail++; $display("FAIL drop_saturate: got %0d want 15", odc[0]); end
    dv[0] = 1'b0; clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    n_cmp++; if (odc[0] != 0) begin n_fail++; $display("FAIL clear_only: got %0d want 0", odc[0]); end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 10; i++) begin
      dv[0] = 1'b1; dd[0] = $urandom;
      dv[1] = 1'b1; dd[1] = $urandom;
      tick();
    end
    idle();
    rst = 1'b1;
    #1;
    model_clear();
    for (int x = 0; x < 2; x++) begin
      n_cmp++; if (ov[x] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid[%0d]: got %0b want 0", x, ov[x]); end
      n_cmp++; if (od[x] !== 32'h0) begin n_fail++; $display("FAIL midrst_dout[%0d]: got %h want 0", x, od[x]); end
      n_cmp++; if (ofl[x] != 0) begin n_fail++; $display("FAIL midrst_fill[%0d]: got %0d want 0", x, ofl[x]); end
      n_cmp++; if (ordy[x] !== 1'b0) begin n_fail++; $display("FAIL midrst_ready[%0d]: got %0b want 0", x, ordy[x]); end
    end
    tick();
    rst = 1'b0;
    tick();
    dv[0] = 1'b1; dd[0] = 32'h1234_5678;
    tick();
    dv[0] = 1'b0;
    tick();
    n_cmp++; if (ov[0] !== 1'b1 || od[0] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL midrst_first_word: got %0b/%h want 1/12345678", ov[0], od[0]);
    end
    drd[0] = 1'b1; tick(); idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int x = 0; x < 2; x++) begin
        dv[x]  = ($urandom_range(0, 3) != 0);
        dd[x]  = $urandom;
        drd[x] = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        clr[x] = ($urandom_range(0, 31) == 0);
      end
      tick();
      for (int x = 0; x < 2; x++) begin
        n_cmp++; if (ov[x] !== exp_valid(x)) begin n_fail++; $display("FAIL rand_valid[%0d] cyc %0d: got %0b want %0b", x, cyc, ov[x], exp_valid(x)); end
        if (exp_valid(x)) begin
          n_cmp++; if (od[x] !== exp_dout(x)) begin n_fail++; $display("FAIL rand_dout[%0d] cyc %0d: got %h want %h", x, cyc, od[x], exp_dout(x)); end
        end
        n_cmp++; if (ofl[x] != mn[x]) begin n_fail++; $display("FAIL rand_fill[%0d] cyc %0d: got %0d want %0d", x, cyc, ofl[x], mn[x]); end
        n_cmp++; if (ordy[x] !== exp_rdy(x)) begin n_fail++; $display("FAIL rand_ready[%0d] cyc %0d: got %0b want %0b", x, cyc, ordy[x], exp_rdy(x)); end
        n_cmp++; if (odc[x] != mdc[x]) begin n_fail++; $display("FAIL rand_drop[%0d] cyc %0d: got %0d want %0d", x, cyc, odc[x], mdc[x]); end
      end
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    model_clear();
    test_reset();
    test_single_push();
    test_stream();
    test_drop_full();
    test_backpressure();
    test_empty_pop_and_clear();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
